// File: rtl/imem_byte_loader_if.sv
// Byte stream from the UART receiver into the loader, and the serial write port out to the imem.
interface imem_byte_loader_if;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic [7:0] imem_byte;
  logic       imem_we;

  modport master (
    input  byte_valid,
    input  rx_byte,
    output imem_byte,
    output imem_we
  );

  modport slave (
    output byte_valid,
    output rx_byte,
    input  imem_byte,
    input  imem_we
  );
endinterface

// File: rtl/imem_byte_loader.sv
// Parses A5/LEN/payload/CSUM frames and replays each payload byte to the imem with a STROBE_CYCLES wide write pulse.
// Pulse starts 2 cycles after a byte is accepted; no backpressure, so a byte arriving mid-strobe aborts the load.
module imem_byte_loader #(
  parameter int MAX_BYTES      = 128,
  parameter int STROBE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic               clk,
  input  logic               rst_n,
  imem_byte_loader_if.master bus,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [1:0]         err_code,
  output logic [7:0]         bytes_loaded
);
  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]      SC_FALL  = 4'(STROBE_CYCLES);
  localparam logic [3:0]      SC_LAST  = 4'(STROBE_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     LEN_MAX  = 16'(MAX_BYTES);

  typedef enum logic [2:0] {
    SYNC, LEN_HI, LEN_LO, PAYLOAD, STROBE, CSUM, DONE, ERROR
  } state_t;

  state_t          state, next_state;
  logic [7:0]      len_hi, len, csum;
  logic [3:0]      scnt;
  logic            ovr;
  logic [TW-1:0]   tcnt;
  logic            timed, tmo, err_set;
  logic [1:0]      err_val;
  logic [15:0]     len_in;

  assign len_in    = {len_hi, bus.rx_byte};
  assign timed     = state inside {LEN_HI, LEN_LO, PAYLOAD, CSUM};
  assign tmo       = timed && !bus.byte_valid && (tcnt == TMO_LAST);
  assign cpu_hold  = (state != DONE);
  assign load_done = (state == DONE);
  assign load_err  = (state == ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SYNC;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    err_val    = 2'd0;
    case (state)
      SYNC:    if (bus.byte_valid && bus.rx_byte == 8'hA5) next_state = LEN_HI;
      LEN_HI:  if (bus.byte_valid) next_state = LEN_LO;
      LEN_LO: begin
        if (bus.byte_valid) begin
          if (len_in == 16'd0 || len_in > LEN_MAX) begin
            next_state = ERROR;
            err_set    = 1'b1;
            err_val    = 2'd1;
          end else begin
            next_state = PAYLOAD;
          end
        end
      end
      PAYLOAD: if (bus.byte_valid) next_state = STROBE;
      STROBE: begin
        // Decide only after the trailing low cycle so an overrun never truncates the pulse.
        if (scnt == SC_LAST) begin
          if (ovr || bus.byte_valid) begin
            next_state = ERROR;
            err_set    = 1'b1;
            err_val    = 2'd2;
          end else if (bytes_loaded == len) begin
            next_state = CSUM;
          end else begin
            next_state = PAYLOAD;
          end
        end
      end
      CSUM: begin
        if (bus.byte_valid) begin
          if (bus.rx_byte == csum) begin
            next_state = DONE;
          end else begin
            next_state = ERROR;
            err_set    = 1'b1;
            err_val    = 2'd3;
          end
        end
      end
      default: ;
    endcase
    if (tmo) begin
      next_state = ERROR;
      err_set    = 1'b1;
      err_val    = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.imem_byte <= 8'd0;
      bus.imem_we   <= 1'b0;
      err_code      <= 2'd0;
      bytes_loaded  <= 8'd0;
      len_hi        <= 8'd0;
      len           <= 8'd0;
      csum          <= 8'd0;
      scnt          <= 4'd0;
      ovr           <= 1'b0;
      tcnt          <= '0;
    end else begin
      bus.imem_we <= (state == STROBE) && (scnt < SC_FALL);
      if (err_set) err_code <= err_val;
      // Idle gap is measured from the last byte, or from re-entry into PAYLOAD after a strobe.
      if (!timed)                tcnt <= '0;
      else if (bus.byte_valid)   tcnt <= TW'(1);
      else                       tcnt <= tcnt + 1'b1;
      case (state)
        LEN_HI:  if (bus.byte_valid) len_hi <= bus.rx_byte;
        LEN_LO:  if (bus.byte_valid) len <= bus.rx_byte;
        PAYLOAD: begin
          if (bus.byte_valid) begin
            bus.imem_byte <= bus.rx_byte;
            scnt          <= 4'd0;
            ovr           <= 1'b0;
          end
        end
        STROBE: begin
          scnt <= scnt + 4'd1;
          if (bus.byte_valid) ovr <= 1'b1;
          if (scnt == SC_FALL) begin
            bytes_loaded <= bytes_loaded + 8'd1;
            csum         <= csum + bus.imem_byte;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_byte_loader.sv
// Randomized and directed frames checked against a frame-level parse model with gap-based timing rules.
module tb_imem_byte_loader;
  localparam int S    = 2;
  localparam int T    = 16;
  localparam int MAXB = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_byte_loader_if bus ();
  logic       cpu_hold, load_done, load_err;
  logic [1:0] err_code;
  logic [7:0] bytes_loaded;

  imem_byte_loader #(.MAX_BYTES(MAXB), .STROBE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .err_code     (err_code),
    .bytes_loaded (bytes_loaded)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: records the byte at each rising imem_we, pulse widths and data stability.
  logic [7:0] got_q[$];
  int         bad_width = 0;
  int         unstable  = 0;
  int         wcnt      = 0;
  logic       we_d      = 1'b0;
  logic [7:0] held      = 8'd0;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (!we_d) begin
        got_q.push_back(bus.imem_byte);
        held = bus.imem_byte;
        wcnt = 1;
      end else begin
        wcnt++;
        if (bus.imem_byte !== held) unstable++;
      end
    end else if (we_d && wcnt != S) begin
      bad_width++;
    end
    we_d = (bus.imem_we === 1'b1);
  end

  task automatic clear_mon();
    got_q.delete();
    bad_width = 0;
    unstable  = 0;
    wcnt      = 0;
    we_d      = 1'b0;
  endtask

  // Frame under test: bytes and the cycle gap from the previous byte_valid.
  logic [7:0] fb[$];
  int         fg[$];
  logic [7:0] exp_q[$];
  logic       exp_done;
  logic [1:0] exp_code;
  int         exp_loaded;

  task automatic add(input logic [7:0] b, input int g);
    fb.push_back(b);
    fg.push_back(g);
  endtask

  function automatic bit ok_gap(input int k, input bit after_pay);
    return after_pay ? (fg[k] <= S + 2 + T) : (fg[k] <= T - 1);
  endfunction

  task automatic model();
    int         i;
    int         k;
    int         plen;
    logic [7:0] sum;
    exp_q.delete();
    exp_done   = 1'b0;
    exp_code   = 2'd0;
    exp_loaded = 0;
    sum        = 8'd0;
    i          = 0;
    while (i < fb.size() && fb[i] != 8'hA5) i++;
    if (i >= fb.size()) return;
    if (i + 2 >= fb.size() || !ok_gap(i + 1, 1'b0) || !ok_gap(i + 2, 1'b0)) begin
      exp_code = 2'd2;
      return;
    end
    plen = {fb[i+1], fb[i+2]};
    if (plen == 0 || plen > MAXB) begin
      exp_code = 2'd1;
      return;
    end
    for (int p = 0; p < plen; p++) begin
      k = i + 3 + p;
      if (k >= fb.size() || !ok_gap(k, p > 0)) begin
        exp_code = 2'd2;
        return;
      end
      exp_q.push_back(fb[k]);
      sum += fb[k];
      exp_loaded++;
      if (k + 1 < fb.size() && fg[k+1] <= S + 2) begin
        exp_code = 2'd2;
        return;
      end
    end
    k = i + 3 + plen;
    if (k >= fb.size() || !ok_gap(k, 1'b1)) exp_code = 2'd2;
    else if (fb[k] == sum)                  exp_done = 1'b1;
    else                                    exp_code = 2'd3;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.rx_byte    = b;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);
    clear_mon();
  endtask

  task automatic run_frame(input string tag);
    model();
    for (int i = 0; i < fb.size(); i++) begin
      if (i > 0) wait_cyc(fg[i] - 1);
      pulse(fb[i]);
    end
    wait_cyc(12);
    @(negedge clk);
    check($sformatf("%s.done", tag), load_done, exp_done);
    check($sformatf("%s.hold", tag), cpu_hold, !exp_done);
    check($sformatf("%s.err", tag), load_err, exp_code != 2'd0);
    check($sformatf("%s.code", tag), err_code, exp_code);
    check($sformatf("%s.loaded", tag), bytes_loaded, exp_loaded);
    check($sformatf("%s.nstrobe", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s.byte%0d", tag, i), got_q[i], exp_q[i]);
    check($sformatf("%s.width", tag), bad_width, 0);
    check($sformatf("%s.stable", tag), unstable, 0);
    check($sformatf("%s.we_idle", tag), bus.imem_we, 1'b0);
    #1;
  endtask

  task automatic frame_t1();
    fb.delete(); fg.delete();
    add(8'hA5, 1); add(8'h00, 6); add(8'h04, 6);
    add(8'h00, 6); add(8'h00, 6); add(8'h00, 6); add(8'h13, 6); add(8'h13, 6);
  endtask

  task automatic gen_random();
    int         ng;
    int         mode;
    int         ov;
    logic [15:0] len;
    logic [7:0] b;
    logic [7:0] sum;
    int         g;
    fb.delete(); fg.delete();
    ng = $urandom_range(0, 2);
    for (int i = 0; i < ng; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h3C;
      add(b, $urandom_range(1, 4));
    end
    mode = $urandom_range(0, 7);
    if (mode == 0) len = ($urandom_range(0, 1) == 1) ? 16'd0 : 16'($urandom_range(129, 300));
    else           len = 16'($urandom_range(1, 8));
    add(8'hA5, $urandom_range(1, 4));
    add(len[15:8], $urandom_range(1, 6));
    add(len[7:0], $urandom_range(1, 6));
    if (mode == 0) begin
      add(8'h55, 6);
      return;
    end
    ov  = (mode == 2) ? $urandom_range(0, int'(len) - 1) : -1;
    sum = 8'd0;
    for (int p = 0; p < int'(len); p++) begin
      b   = 8'($urandom_range(0, 255));
      sum += b;
      if (p == 0)          g = $urandom_range(1, 6);
      else if (ov == p-1)  g = $urandom_range(1, S + 2);
      else                 g = $urandom_range(S + 3, S + 6);
      add(b, g);
    end
    if (mode == 1) sum ^= 8'($urandom_range(1, 255));
    add(sum, (ov == int'(len) - 1) ? $urandom_range(1, S + 2) : $urandom_range(S + 3, S + 6));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.byte_valid = 1'b0;
    bus.rx_byte    = 8'h00;
    #2;
    check("rst.we", bus.imem_we, 1'b0);
    check("rst.byte", bus.imem_byte, 8'h00);
    check("rst.hold", cpu_hold, 1'b1);
    check("rst.done", load_done, 1'b0);
    check("rst.err", load_err, 1'b0);
    check("rst.code", err_code, 2'd0);
    check("rst.loaded", bytes_loaded, 8'd0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);
    clear_mon();

    frame_t1();
    run_frame("t1");

    do_reset();
    fb.delete(); fg.delete();
    add(8'hA5, 1); add(8'h00, 6); add(8'h02, 6); add(8'h11, 6); add(8'h22, 6); add(8'h00, 6);
    run_frame("t2");

    do_reset();
    fb.delete(); fg.delete();
    add(8'h3C, 1); add(8'h5A, 3); add(8'hA5, 3); add(8'h00, 3); add(8'h81, 3);
    run_frame("t3");

    do_reset();
    fb.delete(); fg.delete();
    add(8'hA5, 1); add(8'h00, 6); add(8'h02, 6); add(8'hAA, 6); add(8'hBB, 2);
    run_frame("t4");

    // Timeout: error must appear exactly T cycles after the last byte.
    do_reset();
    pulse(8'hA5); wait_cyc(2);
    pulse(8'h00); wait_cyc(2);
    pulse(8'h01);
    wait_cyc(T - 2);
    @(negedge clk);
    check("t5.err_early", load_err, 1'b0);
    @(negedge clk);
    check("t5.err", load_err, 1'b1);
    check("t5.code", err_code, 2'd2);
    check("t5.hold", cpu_hold, 1'b1);
    #1;

    // Reset in the middle of a strobe, then a fresh load.
    do_reset();
    pulse(8'hA5); wait_cyc(5);
    pulse(8'h00); wait_cyc(5);
    pulse(8'h04); wait_cyc(5);
    pulse(8'h00);
    wait_cyc(1);
    check("t6.we_pre", bus.imem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6.we_rst", bus.imem_we, 1'b0);
    check("t6.hold_rst", cpu_hold, 1'b1);
    check("t6.byte_rst", bus.imem_byte, 8'h00);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);
    clear_mon();
    frame_t1();
    run_frame("t6");

    for (int r = 0; r < 16; r++) begin
      do_reset();
      gen_random();
      run_frame($sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
